// File: rtl/bridge_pkg.sv
// Shared constants and FSM state type for the valid/ready to req/ack bridge.
package bridge_pkg;

  localparam int unsigned BRIDGE_WIDTH = 32'd8;
  localparam int unsigned BRIDGE_DEPTH = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read; DEPTH must be a power of two.
module sync_fifo
  import bridge_pkg::*;
#(
  parameter int unsigned WIDTH = BRIDGE_WIDTH,
  parameter int unsigned DEPTH = BRIDGE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == CNT_FULL);
  assign empty_s   = (count_r == CW'(0));
  // Guards keep a misbehaving caller from overwriting or underflowing.
  assign do_push_s = push & ~full_s;
  assign do_pop_s  = pop & ~empty_s;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write; contents are don't-care until a push lands.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/valid_req_bridge_checker.sv
// Protocol properties observable on the bridge's external ports.
module valid_req_bridge_checker #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  input logic             en,
  input logic             ready,
  input logic             req,
  input logic             ack,
  input logic [WIDTH-1:0] data_out
);

  a_no_ready_in_reset: assert property (@(posedge clk) rst |-> !ready);

  a_ready_needs_en: assert property (@(posedge clk) ready |-> en);

  // An unanswered request holds its word until ack or reset.
  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (req && !ack) |=> (rst || (req && $stable(data_out))));

  a_req_drop: assert property (@(posedge clk) disable iff (rst)
    (req && ack) |=> !req);

endmodule

// File: rtl/valid_req_bridge.sv
// Buffers valid/ready words and forwards each one with a four-phase req/ack handshake.
module valid_req_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned WIDTH = BRIDGE_WIDTH,
  parameter int unsigned DEPTH = BRIDGE_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             req,
  input  logic             ack,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  bridge_state_e    state_r;
  logic             req_r;
  logic [WIDTH-1:0] data_out_r;

  logic             ready_s;
  logic             push_s;
  logic             pop_s;
  logic             start_s;
  logic [WIDTH-1:0] fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [CW-1:0]    fifo_count_s;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (data_in),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // The count bound backs up the full flag so a corrupted flag cannot admit a word.
  assign ready_s = en & ~rst & ~fifo_full_s & (fifo_count_s < CW'(DEPTH));
  assign push_s  = valid & ready_s;
  assign pop_s   = (state_r == ST_REQ) & ack;
  assign start_s = en & ~fifo_empty_s & ~ack;

  // Downstream handshake sequencer; req and data_out are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      req_r      <= 1'b0;
      data_out_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            data_out_r <= fifo_head_s;
            req_r      <= 1'b1;
            state_r    <= ST_REQ;
          end else begin
            req_r      <= 1'b0;
          end
        end
        ST_REQ: begin
          if (ack) begin
            req_r   <= 1'b0;
            state_r <= ST_RELEASE;
          end else begin
            req_r   <= 1'b1;
          end
        end
        ST_RELEASE: begin
          req_r <= 1'b0;
          if (!ack) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RELEASE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = ready_s;
  assign req      = req_r;
  assign data_out = data_out_r;

endmodule

// File: tb/tb_valid_req_bridge.sv
// Scenario and randomized bench for valid_req_bridge against a queue-based model.
module tb_valid_req_bridge;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       valid = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready;
  logic       req;
  logic [7:0] data_out;

  int total = 0;
  int bad = 0;

  logic [7:0] mq [$];
  logic [7:0] got [$];
  bit         rel = 1'b0;

  valid_req_bridge #(.WIDTH(8), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .valid    (valid),
    .data_in  (data_in),
    .ready    (ready),
    .req      (req),
    .ack      (ack),
    .data_out (data_out)
  );

  valid_req_bridge_checker #(.WIDTH(8)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ready    (ready),
    .req      (req),
    .ack      (ack),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // One clock edge: update the model from the pre-edge inputs, then check outputs.
  task automatic tick();
    logic       pr_req;
    logic [7:0] pr_do;
    logic [7:0] pd;
    bit         pv, pe, prst, pa;
    bit         push_e, pop_e, rise_e, exp_req, exp_ready;
    int         sz;
    pr_req = req; pr_do = data_out; pd = data_in;
    pv = valid; pe = en; prst = rst; pa = ack;
    sz = mq.size();
    @(posedge clk);
    #1;
    if (prst) begin
      mq.delete();
      rel = 1'b0;
      total++;
      if (req !== 1'b0 || data_out !== 8'h00) begin
        bad++;
        $display("FAIL reset_out: req=%0b data_out=%h want req=0 data_out=00", req, data_out);
      end
    end else begin
      push_e = pv && pe && (sz < D);
      pop_e  = (pr_req === 1'b1) && pa;
      rise_e = (pr_req === 1'b0) && !rel && pe && !pa && (sz > 0);
      if (pop_e) begin
        void'(mq.pop_front());
        rel = 1'b1;
      end else if (!pa) begin
        rel = 1'b0;
      end
      if (push_e) mq.push_back(pd);
      exp_req = (pr_req === 1'b1) ? !pa : rise_e;
      total++;
      if (req !== exp_req) begin
        bad++;
        $display("FAIL req_seq: req=%0b want %0b at %0t", req, exp_req, $time);
      end
      if (req === 1'b1) begin
        total++;
        if (mq.size() == 0) begin
          bad++;
          $display("FAIL data_head: req=1 data_out=%h but no word queued", data_out);
        end else if (data_out !== mq[0]) begin
          bad++;
          $display("FAIL data_head: data_out=%h want %h", data_out, mq[0]);
        end
        if (pr_req === 1'b0) got.push_back(data_out);
      end
      if (pr_req === 1'b1 && !pa) begin
        total++;
        if (data_out !== pr_do) begin
          bad++;
          $display("FAIL data_stable: data_out=%h want %h", data_out, pr_do);
        end
      end
    end
    exp_ready = en && !rst && (mq.size() < D);
    total++;
    if (ready !== exp_ready) begin
      bad++;
      $display("FAIL ready: ready=%0b want %0b at %0t", ready, exp_ready, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    valid = 1'b1;
    data_in = d;
    tick();
    valid = 1'b0;
  endtask

  task automatic handshake();
    int n = 0;
    while (req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (req !== 1'b1) begin
      bad++;
      $display("FAIL hs_timeout: req=%0b want 1 within 20 cycles", req);
    end else begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; valid = 1'b0; ack = 1'b0; data_in = 8'h00;
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_in_rst: ready=%0b want 0", ready);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_rst: ready=%0b want 1", ready);
    end
    repeat (3) tick();
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL idle_req: req=%0b want 0", req);
    end
  endtask

  task automatic test_single();
    got.delete();
    push(8'hA5);
    tick();
    total++;
    if (req !== 1'b1 || data_out !== 8'hA5) begin
      bad++;
      $display("FAIL single_req: req=%0b data_out=%h want 1 a5", req, data_out);
    end
    ack = 1'b1;
    tick();
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL single_drop: req=%0b want 0", req);
    end
    ack = 1'b0;
    tick();
    tick();
    total++;
    if (req !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL single_empty: req=%0b ready=%0b want 0 1", req, ready);
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03; exp_b[3] = 8'h04;
    got.delete();
    for (int i = 0; i < 4; i++) push(exp_b[i]);
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL burst_full: ready=%0b want 0", ready);
    end
    push(8'h05);
    repeat (4) handshake();
    repeat (3) tick();
    total++;
    if (got.size() != 4 || req !== 1'b0) begin
      bad++;
      $display("FAIL burst_count: words=%0d req=%0b want 4 0", got.size(), req);
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL burst_order: word%0d=%h want %h", i, got[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_interleaved();
    logic [7:0] exp_i [3];
    exp_i[0] = 8'h10; exp_i[1] = 8'h11; exp_i[2] = 8'h12;
    got.delete();
    push(8'h10);
    push(8'h11);
    handshake();
    push(8'h12);
    handshake();
    push(8'h13);
    handshake();
    tick();
    tick();
    total++;
    if (got.size() < 3) begin
      bad++;
      $display("FAIL inter_count: words=%0d want at least 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_i[i]) begin
        bad++;
        $display("FAIL inter_order: word%0d=%h want %h", i, got[i], exp_i[i]);
      end
    end
    total++;
    if (req !== 1'b1 || data_out !== 8'h13) begin
      bad++;
      $display("FAIL inter_pending: req=%0b data_out=%h want 1 13", req, data_out);
    end
    handshake();
    tick();
  endtask

  task automatic test_enable();
    en = 1'b1;
    push(8'h55);
    en = 1'b0;
    valid = 1'b1;
    data_in = 8'h66;
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL en_ready: ready=%0b want 0", ready);
    end
    repeat (3) tick();
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL en_noreq: req=%0b want 0", req);
    end
    valid = 1'b0;
    en = 1'b1;
    tick();
    total++;
    if (req !== 1'b1 || data_out !== 8'h55) begin
      bad++;
      $display("FAIL en_resume: req=%0b data_out=%h want 1 55", req, data_out);
    end
    handshake();
    repeat (2) tick();
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL en_no66: req=%0b want 0", req);
    end
  endtask

  task automatic test_stale_ack();
    ack = 1'b1;
    push(8'h3C);
    repeat (3) tick();
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL stale_ack: req=%0b want 0", req);
    end
    ack = 1'b0;
    tick();
    total++;
    if (req !== 1'b1 || data_out !== 8'h3C) begin
      bad++;
      $display("FAIL stale_release: req=%0b data_out=%h want 1 3c", req, data_out);
    end
    handshake();
    tick();
  endtask

  task automatic test_midreset();
    push(8'h77);
    push(8'h78);
    total++;
    if (req !== 1'b1) begin
      bad++;
      $display("FAIL mid_req: req=%0b want 1", req);
    end
    rst = 1'b1;
    tick();
    total++;
    if (req !== 1'b0 || data_out !== 8'h00) begin
      bad++;
      $display("FAIL mid_rst: req=%0b data_out=%h want 0 00", req, data_out);
    end
    rst = 1'b0;
    repeat (4) tick();
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL mid_discard: req=%0b want 0", req);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      en      = ($urandom_range(0, 9) != 0);
      valid   = $urandom_range(0, 1) == 1;
      data_in = 8'($urandom);
      if (req === 1'b1) ack = ($urandom_range(0, 3) != 0);
      else              ack = ($urandom_range(0, 5) == 0);
      tick();
    end
    rst = 1'b0; en = 1'b1; valid = 1'b0; ack = 1'b0;
    tick();
    for (int k = 0; k < 8 && mq.size() > 0; k++) handshake();
    repeat (3) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_interleaved();
    test_enable();
    test_stale_ack();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/valid_req_bridge.md
Name: valid_req_bridge

Overview:
- Buffered protocol bridge between a valid/ready producer and a four-phase req/ack consumer.
- Accepts words from the upstream sender, stores them in an internal FIFO, and forwards each word downstream using a full four-phase request/acknowledge handshake.
- Decouples the two sides so that the producer can push several words before the consumer starts draining.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, FIFO capacity in words; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  bridge enable.
- valid  input  1  upstream word on data_in is valid.
- data_in  input  WIDTH  upstream data.
- ready  output  1  bridge can accept an upstream word this cycle.
- req  output  1  downstream request; data_out is valid while req=1.
- ack  input  1  downstream acknowledge.
- data_out  output  WIDTH  downstream data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO is emptied (pointers and count = 0).
  - FSM goes to IDLE.
  - req=0 and data_out=0.
  - ready is forced to 0 combinationally while rst=1.
- Upstream side:
  - ready = en & !full & !rst, decoded combinationally from registered count.
  - A push occurs on a clk edge with valid & ready; data_in is written at the write pointer.
  - With valid=0 or ready=0 there is no push and data_in is ignored.
- Downstream FSM with states IDLE, REQ, RELEASE:
  - IDLE: if en & !empty & !ack, then data_out <= FIFO head, req <= 1, go to REQ. Otherwise hold, with req=0.
  - REQ: req stays 1 and data_out stays stable. When ack=1, pop the FIFO head, set req <= 0, go to RELEASE.
  - RELEASE: req=0. When ack=0, go to IDLE.
  - Earliest next req rise is one cycle after ack falls.
- Latency:
  - Push into an empty FIFO at edge N: req=1 and data_out valid after edge N+1, provided en=1 and ack=0.
  - Ack seen at edge M: req=0 after edge M.
- en=0:
  - ready=0 and IDLE does not start a new request.
  - A handshake already in REQ or RELEASE completes normally.
  - FIFO contents are retained.
- Boundary conditions:
  - Full: ready=0; no overwrite.
  - Empty: no request is issued.
  - Push and pop on the same edge: count is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Words are delivered in strict FIFO order, with no loss and no duplication.
  - ack=1 while in IDLE (stale ack): no request is started until ack=0.
  - rst asserted mid-handshake: req drops after that edge and the FIFO contents are discarded.
- Count width is clog2(DEPTH)+1 bits; full is count==DEPTH; empty is count==0.

Decomposition:
- Shared package bridge_pkg:
  - default WIDTH and DEPTH constants;
  - FSM state enum (IDLE, REQ, RELEASE) as a typedef.
- One natural sub-module, sync_fifo, parameterised by WIDTH and DEPTH:
  - inputs: push, pop, din;
  - outputs: dout (head, combinational read), full, empty, count.
- The FSM and the ready decode live in valid_req_bridge.

Test Plan:
- Reset then idle: assert rst for 2 cycles with en=1 -> req=0, data_out=0, ready=0 during reset; after release ready=1, req stays 0.
- Single transfer:
  - Stimulus: push 8'hA5 with valid for one cycle, then ack follows req (ack rises 1 cycle after req, falls 1 cycle after req falls).
  - Response: req rises one cycle after the push with data_out=8'hA5; req falls after the ack edge; FIFO is empty at the end.
- Burst then drain:
  - Stimulus: push 8'h01, 8'h02, 8'h03, 8'h04 back-to-back with ack held 0, then a fifth valid, then run the consumer.
  - Response: ready=0 after 4 pushes; the fifth word is not accepted; the consumer receives 01, 02, 03, 04 in order.
- Interleaved:
  - Stimulus: push 8'h10, push 8'h11, one handshake, push 8'h12, one handshake, push 8'h13, one handshake.
  - Response: received sequence is 10, 11, 12; 8'h13 remains queued with req=1.
- Enable gating:
  - Stimulus: en=0 with the FIFO holding 8'h55 and valid=1 on data_in 8'h66.
  - Response: ready=0, no new req, 8'h66 not accepted. When en=1 again, req rises with 8'h55.
- Mid-handshake reset: assert rst while req=1 -> req=0 and data_out=0 after that edge; FIFO empty; no further req without a new push.
